// File: rtl/pc_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Brief    : Flow, branch-type and state encodings plus default vectors.
// Revision : 1.0
// ============================================================================
package pc_gen_pkg;

    typedef enum logic [2:0] {
        FLOW_SEQ  = 3'd0,
        FLOW_BR   = 3'd1,
        FLOW_J    = 3'd2,
        FLOW_JAL  = 3'd3,
        FLOW_JR   = 3'd4,
        FLOW_ERET = 3'd5
    } flow_e;

    typedef enum logic [2:0] {
        BT_BEQ  = 3'd0,
        BT_BNE  = 3'd1,
        BT_BLTZ = 3'd2,
        BT_BGEZ = 3'd3,
        BT_BGTZ = 3'd4,
        BT_BLEZ = 3'd5
    } btype_e;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } state_e;

    localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] c_TRAP_VEC  = 32'h0000_0180;

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_gen_if
// Brief    : Control and result bundle between the pipeline and pc_gen.
// Revision : 1.0
// ============================================================================
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             pc_wr;
    logic [2:0]       flow;
    logic [2:0]       btype;
    logic             zero;
    logic             sign;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-7:0] jidx;
    logic [WIDTH-1:0] rs_val;
    logic             trap_req;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] link;
    logic             link_we;
    logic [WIDTH-1:0] epc;
    logic             in_handler;
    logic             taken;
    logic             addr_err;
    logic             nest_err;

    modport master (
        output pc_wr, flow, btype, zero, sign, imm, jidx, rs_val, trap_req,
        input  pc, next_pc, link, link_we, epc, in_handler, taken, addr_err, nest_err
    );

    modport slave (
        input  pc_wr, flow, btype, zero, sign, imm, jidx, rs_val, trap_req,
        output pc, next_pc, link, link_we, epc, in_handler, taken, addr_err, nest_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen_br_cond.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : br_cond
// Brief    : Branch-taken decision from branch type and ALU flags.
// Revision : 1.0
// ============================================================================
module br_cond
    import pc_gen_pkg::*;
(
    input  logic [2:0] btype,
    input  logic       zero,
    input  logic       sign,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (btype)
            BT_BEQ:  cond = zero;
            BT_BNE:  cond = ~zero;
            BT_BLTZ: cond = sign;
            BT_BGEZ: cond = ~sign;
            BT_BGTZ: cond = ~sign & ~zero;
            BT_BLEZ: cond = sign | zero;
            default: cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Program counter with branch/jump redirect, single-level trap/ERET.
// Revision : 1.0
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(c_RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(c_TRAP_VEC)
) (
    input  logic      clk,
    input  logic      reset,
    pc_gen_if.slave   bus
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    state_e           r_state;
    logic             r_nest_err;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_j_tgt;
    logic [WIDTH-1:0] w_next;
    logic             w_taken;
    logic             w_cond;
    logic             w_addr_err;
    logic             w_trap_src;
    logic             w_accept;
    logic             w_nest;
    logic             w_eret_ok;

    br_cond u_br_cond (
        .btype (bus.btype),
        .zero  (bus.zero),
        .sign  (bus.sign),
        .cond  (w_cond)
    );

    assign w_seq      = r_pc + WIDTH'(4);
    assign w_br_tgt   = w_seq + (bus.imm << 2);
    assign w_j_tgt    = {w_seq[WIDTH-1:WIDTH-4], bus.jidx, 2'b00};
    assign w_addr_err = (bus.flow == FLOW_JR) && (bus.rs_val[1:0] != 2'b00);
    assign w_trap_src = bus.trap_req | w_addr_err;
    assign w_accept   = bus.pc_wr & (r_state == ST_NORMAL) & w_trap_src;
    assign w_nest     = bus.pc_wr & (r_state == ST_HANDLER) & w_trap_src;
    assign w_eret_ok  = (bus.flow == FLOW_ERET) && (r_state == ST_HANDLER);

    always_comb begin
        w_next  = w_seq;
        w_taken = 1'b0;
        if (reset) begin
            w_next = RESET_VEC;
        end else if (!bus.pc_wr) begin
            w_next = r_pc;
        end else if (w_accept) begin
            w_next  = TRAP_VEC;
            w_taken = 1'b1;
        end else begin
            case (bus.flow)
                FLOW_BR: begin
                    w_next  = w_cond ? w_br_tgt : w_seq;
                    w_taken = w_cond;
                end
                FLOW_J, FLOW_JAL: begin
                    w_next  = w_j_tgt;
                    w_taken = 1'b1;
                end
                FLOW_JR: begin
                    // A misaligned target only gets here inside the handler; fall through to SEQ.
                    w_next  = w_addr_err ? w_seq : bus.rs_val;
                    w_taken = ~w_addr_err;
                end
                FLOW_ERET: begin
                    w_next  = w_eret_ok ? r_epc : w_seq;
                    w_taken = w_eret_ok;
                end
                default: begin
                    w_next  = w_seq;
                    w_taken = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_state    <= ST_NORMAL;
            r_nest_err <= 1'b0;
        end else if (bus.pc_wr) begin
            r_pc <= w_next;
            case (r_state)
                ST_NORMAL: begin
                    if (w_accept) begin
                        r_epc   <= r_pc;
                        r_state <= ST_HANDLER;
                    end
                end
                ST_HANDLER: begin
                    if (bus.flow == FLOW_ERET) begin
                        r_state <= ST_NORMAL;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
            if (w_nest) begin
                r_nest_err <= 1'b1;
            end
        end
    end

    assign bus.pc         = r_pc;
    assign bus.next_pc    = w_next;
    assign bus.link       = w_seq;
    assign bus.link_we    = ~reset & bus.pc_wr & (bus.flow == FLOW_JAL) & ~w_accept;
    assign bus.epc        = r_epc;
    assign bus.in_handler = (r_state == ST_HANDLER);
    assign bus.taken      = w_taken;
    assign bus.addr_err   = w_addr_err;
    assign bus.nest_err   = r_nest_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Scenario bench for pc_gen with a queued PC scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(W)) bus ();

    pc_gen #(
        .WIDTH     (W),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    // Every non-reset edge consumes one expected PC pushed by the driving task.
    always @(posedge clk) begin
        if (!reset) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow pc=%h with nothing expected", bus.pc);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bus.pc !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_pc got=%h exp=%h", bus.pc, sb_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic drive(input logic pw, input logic [2:0] fl, input logic [2:0] bt,
                         input logic z, input logic s, input logic [31:0] im,
                         input logic [25:0] ji, input logic [31:0] rs, input logic tr);
        bus.pc_wr = pw; bus.flow = fl; bus.btype = bt; bus.zero = z; bus.sign = s;
        bus.imm = im; bus.jidx = ji; bus.rs_val = rs; bus.trap_req = tr;
    endtask

    task automatic tick(input logic [31:0] exp_pc);
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #2;
    endtask

    task automatic set_pc(input logic [31:0] a);
        drive(1'b1, FLOW_JR, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, a, 1'b0);
        #1;
        tick(a);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, FLOW_JAL, 3'd0, 1'b0, 1'b0, 32'h0, 26'h3, 32'h0, 1'b0);
        #1;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", bus.pc); end
        checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL rst_epc got=%h exp=0", bus.epc); end
        checks++; if (bus.in_handler !== 1'b0) begin errors++; $display("FAIL rst_state got=%b exp=0", bus.in_handler); end
        checks++; if (bus.nest_err !== 1'b0) begin errors++; $display("FAIL rst_nest got=%b exp=0", bus.nest_err); end
        checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL rst_next got=%h exp=0", bus.next_pc); end
        checks++; if (bus.taken !== 1'b0 || bus.link_we !== 1'b0) begin errors++; $display("FAIL rst_taken_lwe got=%b%b exp=00", bus.taken, bus.link_we); end
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_seq;
        logic [31:0] m;
        m = 32'h0;
        drive(1'b1, FLOW_SEQ, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL seq_start got=%h exp=0", bus.pc); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.next_pc !== m + 32'h4) begin errors++; $display("FAIL seq_next got=%h exp=%h", bus.next_pc, m + 32'h4); end
            tick(m + 32'h4);
            m = m + 32'h4;
            #1;
        end
    endtask

    task automatic test_branch;
        set_pc(32'h100);
        drive(1'b1, FLOW_BR, BT_BNE, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'hFC || bus.taken !== 1'b1) begin errors++; $display("FAIL bne_taken got=%h/%b exp=fc/1", bus.next_pc, bus.taken); end
        bus.zero = 1'b1;
        #1;
        checks++; if (bus.next_pc !== 32'h104 || bus.taken !== 1'b0) begin errors++; $display("FAIL bne_not got=%h/%b exp=104/0", bus.next_pc, bus.taken); end
        tick(32'h104);
        drive(1'b1, FLOW_BR, BT_BGTZ, 1'b0, 1'b0, 32'h4, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h118 || bus.taken !== 1'b1) begin errors++; $display("FAIL bgtz got=%h/%b exp=118/1", bus.next_pc, bus.taken); end
        tick(32'h118);
        drive(1'b1, FLOW_BR, 3'd6, 1'b1, 1'b1, 32'h4, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h11C || bus.taken !== 1'b0) begin errors++; $display("FAIL bt6 got=%h/%b exp=11c/0", bus.next_pc, bus.taken); end
        tick(32'h11C);
        drive(1'b1, FLOW_BR, BT_BLTZ, 1'b0, 1'b1, 32'h1, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h124 || bus.taken !== 1'b1) begin errors++; $display("FAIL bltz got=%h/%b exp=124/1", bus.next_pc, bus.taken); end
        tick(32'h124);
    endtask

    task automatic test_jal;
        set_pc(32'h4000_0010);
        drive(1'b1, FLOW_JAL, 3'd0, 1'b0, 1'b0, 32'h0, 26'h40, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h4000_0100) begin errors++; $display("FAIL jal_next got=%h exp=40000100", bus.next_pc); end
        checks++; if (bus.link !== 32'h4000_0014 || bus.link_we !== 1'b1) begin errors++; $display("FAIL jal_link got=%h/%b exp=40000014/1", bus.link, bus.link_we); end
        checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL jal_taken got=%b exp=1", bus.taken); end
        tick(32'h4000_0100);
        drive(1'b1, FLOW_J, 3'd0, 1'b0, 1'b0, 32'h0, 26'h10, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h4000_0040 || bus.link_we !== 1'b0) begin errors++; $display("FAIL j_next got=%h/%b exp=40000040/0", bus.next_pc, bus.link_we); end
        tick(32'h4000_0040);
    endtask

    task automatic test_trap;
        set_pc(32'h200);
        drive(1'b1, FLOW_JAL, 3'd0, 1'b0, 1'b0, 32'h0, 26'h40, 32'h0, 1'b1);
        #1;
        checks++; if (bus.next_pc !== 32'h180 || bus.taken !== 1'b1 || bus.link_we !== 1'b0) begin errors++; $display("FAIL trap_next got=%h/%b/%b exp=180/1/0", bus.next_pc, bus.taken, bus.link_we); end
        tick(32'h180);
        checks++; if (bus.epc !== 32'h200 || bus.in_handler !== 1'b1) begin errors++; $display("FAIL trap_epc got=%h/%b exp=200/1", bus.epc, bus.in_handler); end
        drive(1'b1, FLOW_SEQ, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        tick(32'h184);
        drive(1'b1, FLOW_ERET, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h200 || bus.taken !== 1'b1) begin errors++; $display("FAIL eret_next got=%h/%b exp=200/1", bus.next_pc, bus.taken); end
        tick(32'h200);
        checks++; if (bus.in_handler !== 1'b0) begin errors++; $display("FAIL eret_state got=%b exp=0", bus.in_handler); end
        drive(1'b1, FLOW_ERET, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h204 || bus.taken !== 1'b0) begin errors++; $display("FAIL eret_normal got=%h/%b exp=204/0", bus.next_pc, bus.taken); end
        tick(32'h204);
    endtask

    task automatic test_addr_err;
        set_pc(32'h300);
        drive(1'b1, FLOW_JR, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h1002, 1'b0);
        #1;
        checks++; if (bus.addr_err !== 1'b1 || bus.next_pc !== 32'h180 || bus.taken !== 1'b1) begin errors++; $display("FAIL jr_trap got=%b/%h/%b exp=1/180/1", bus.addr_err, bus.next_pc, bus.taken); end
        tick(32'h180);
        checks++; if (bus.epc !== 32'h300 || bus.in_handler !== 1'b1) begin errors++; $display("FAIL jr_epc got=%h/%b exp=300/1", bus.epc, bus.in_handler); end
        #1;
        checks++; if (bus.addr_err !== 1'b1 || bus.next_pc !== 32'h184 || bus.taken !== 1'b0) begin errors++; $display("FAIL jr_nested got=%b/%h/%b exp=1/184/0", bus.addr_err, bus.next_pc, bus.taken); end
        tick(32'h184);
        checks++; if (bus.nest_err !== 1'b1 || bus.epc !== 32'h300) begin errors++; $display("FAIL nest_set got=%b/%h exp=1/300", bus.nest_err, bus.epc); end
        drive(1'b1, FLOW_SEQ, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        tick(32'h188);
        checks++; if (bus.nest_err !== 1'b1) begin errors++; $display("FAIL nest_sticky got=%b exp=1", bus.nest_err); end
        drive(1'b1, FLOW_ERET, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1);
        #1;
        checks++; if (bus.next_pc !== 32'h300 || bus.taken !== 1'b1) begin errors++; $display("FAIL eret_vs_trap got=%h/%b exp=300/1", bus.next_pc, bus.taken); end
        tick(32'h300);
        checks++; if (bus.in_handler !== 1'b0 || bus.nest_err !== 1'b1 || bus.epc !== 32'h300) begin errors++; $display("FAIL eret_vs_trap_state got=%b/%b/%h exp=0/1/300", bus.in_handler, bus.nest_err, bus.epc); end
    endtask

    task automatic test_stall;
        set_pc(32'h50);
        drive(1'b0, FLOW_BR, BT_BEQ, 1'b1, 1'b0, 32'h4, 26'h0, 32'h0, 1'b1);
        #1;
        checks++; if (bus.next_pc !== 32'h50 || bus.taken !== 1'b0 || bus.link_we !== 1'b0) begin errors++; $display("FAIL stall_comb got=%h/%b/%b exp=50/0/0", bus.next_pc, bus.taken, bus.link_we); end
        tick(32'h50);
        tick(32'h50);
        checks++; if (bus.epc !== 32'h300 || bus.in_handler !== 1'b0) begin errors++; $display("FAIL stall_hold got=%h/%b exp=300/0", bus.epc, bus.in_handler); end
    endtask

    task automatic test_wrap;
        set_pc(32'hFFFF_FFFC);
        drive(1'b1, FLOW_SEQ, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=0", bus.next_pc); end
        tick(32'h0);
    endtask

    task automatic test_reset_mid_handler;
        drive(1'b1, FLOW_SEQ, 3'd0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
        #1;
        tick(32'h4);
        bus.trap_req = 1'b1;
        #1;
        tick(32'h180);
        checks++; if (bus.epc !== 32'h4 || bus.in_handler !== 1'b1) begin errors++; $display("FAIL mid_trap got=%h/%b exp=4/1", bus.epc, bus.in_handler); end
        bus.trap_req = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.pc !== 32'h0 || bus.epc !== 32'h0) begin errors++; $display("FAIL async_rst got=%h/%h exp=0/0", bus.pc, bus.epc); end
        checks++; if (bus.in_handler !== 1'b0 || bus.nest_err !== 1'b0 || bus.next_pc !== 32'h0) begin errors++; $display("FAIL async_rst_st got=%b/%b/%h exp=0/0/0", bus.in_handler, bus.nest_err, bus.next_pc); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        tick(32'h4);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jal();
        test_trap();
        test_addr_err();
        test_stall();
        test_wrap();
        test_reset_mid_handler();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, meaning address/data width of all PC-related ports (minimum 16).
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0180, meaning handler entry address on trap.
REQ-004 clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-high reset.
REQ-005 pc_wr  input  1  PC update enable; 0 = stall, PC/EPC/state hold.
REQ-006 flow  input  3  0 SEQ, 1 BR, 2 J, 3 JAL, 4 JR, 5 ERET, 6-7 treated as SEQ.
REQ-007 btype  input  3  0 BEQ, 1 BNE, 2 BLTZ, 3 BGEZ, 4 BGTZ, 5 BLEZ, 6-7 never taken.
REQ-008 zero  input  1  comparison-equal / operand-zero flag; sign  input  1  operand negative flag.
REQ-009 imm  input  WIDTH  sign-extended branch offset in words.
REQ-010 jidx  input  WIDTH-6  jump index field.
REQ-011 rs_val  input  WIDTH  register jump target.
REQ-012 trap_req  input  1  synchronous trap request, level, held by requester.
REQ-013 pc  output  WIDTH  current PC (registered); next_pc  output  WIDTH  combinational next PC.
REQ-014 link  output  WIDTH  pc+4 for JAL write-back; link_we  output  1  high when flow=JAL and no trap taken.
REQ-015 epc  output  WIDTH  saved exception PC (registered); in_handler  output  1  state == HANDLER.
REQ-016 taken  output  1  non-sequential redirect selected this cycle; addr_err  output  1  JR target misaligned.
REQ-017 nest_err  output  1  sticky: trap requested while in HANDLER.

Function
REQ-018 seq = pc + 4, modulo 2^WIDTH (wrap from all-ones region to 0, no flag).
REQ-019 BR target = seq + (imm << 2), modulo 2^WIDTH; taken conditions: BEQ zero, BNE !zero, BLTZ sign, BGEZ !sign, BGTZ !sign & !zero, BLEZ sign | zero.
REQ-020 J/JAL target = {seq[WIDTH-1:WIDTH-4], jidx, 2'b00}.
REQ-021 JR target = rs_val; rs_val[1:0] != 0 asserts addr_err and is handled as a trap.
REQ-022 ERET target = epc, valid only in HANDLER; ERET in NORMAL is treated as SEQ.
REQ-023 Priority, highest first: reset, trap (trap_req or addr_err, NORMAL only), flow redirect, SEQ.
REQ-024 State machine, 2 states: NORMAL -> HANDLER on accepted trap with pc_wr=1; HANDLER -> NORMAL on ERET with pc_wr=1; otherwise hold.
REQ-025 Accepted trap: next_pc = TRAP_VEC, epc <= pc (faulting instruction address) on the edge, link_we = 0, taken = 1.
REQ-026 Trap or addr_err in HANDLER: not accepted, flow proceeds (JR misaligned -> SEQ), nest_err set, clears only on reset.
REQ-027 pc_wr=0: next_pc = pc, taken = 0, link_we = 0, no PC/EPC/state/nest_err update; trap_req ignored.
REQ-028 Latency: pc, epc, state update on the rising edge after the cycle next_pc is computed; next_pc, taken, link, link_we, addr_err combinational, zero-cycle.
REQ-029 Simultaneous ERET and trap_req in HANDLER: ERET wins, nest_err set.

Reset
REQ-030 Reset asserted: pc = RESET_VEC, epc = 0, state NORMAL, nest_err = 0, immediately (asynchronous).
REQ-031 While reset high: next_pc = RESET_VEC, taken = 0, link_we = 0; reset mid-handler discards EPC.

Structure
REQ-032 Shared package holds flow encodings, btype encodings, state encoding, default RESET_VEC/TRAP_VEC.
REQ-033 Sub-module br_cond (btype, zero, sign -> cond) is the one natural split; rest in pc_gen.

Verification
REQ-034 Reset, then 3 cycles SEQ pc_wr=1 -> pc 0x0, 0x4, 0x8, 0xC.
REQ-035 pc=0x100, BR BNE zero=0 imm=0xFFFF_FFFE -> next_pc 0xFC, taken=1; zero=1 -> next_pc 0x104.
REQ-036 pc=0x4000_0010, JAL jidx=0x40 -> next_pc 0x4000_0100, link 0x4000_0014, link_we=1.
REQ-037 pc=0x200 NORMAL, trap_req=1 -> next_pc 0x180, after edge epc 0x200, in_handler=1; later ERET -> pc 0x200, in_handler=0.
REQ-038 NORMAL, JR rs_val=0x1002 -> addr_err=1, trap to 0x180; repeat in HANDLER -> SEQ, nest_err=1 sticky.
REQ-039 pc=0x50, pc_wr=0 with BR taken and trap_req=1 for 2 cycles -> pc stays 0x50, epc, state unchanged.
